// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multicycle multiply/divide unit.
package muldiv_pkg;

  // Widest value the negate helper handles; covers 2*WIDTH for WIDTH up to 64.
  localparam int unsigned MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  // Two's-complement negate; callers truncate to their own width (low bits are exact).
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, result sign correction on exit.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg_a,
  output logic               o_neg_b,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic               i_is_div,
  input  logic               i_neg_res,
  input  logic               i_neg_rem,
  output logic [2*WIDTH-1:0] o_fixed
);
  import muldiv_pkg::*;

  localparam int unsigned DW = 2 * WIDTH;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  // Operand magnitudes; unsigned ops pass through untouched.
  always_comb begin
    o_neg_a = i_signed & i_a[WIDTH-1];
    o_neg_b = i_signed & i_b[WIDTH-1];
    o_mag_a = o_neg_a ? WIDTH'(twos_neg(MAX_W'(i_a))) : i_a;
    o_mag_b = o_neg_b ? WIDTH'(twos_neg(MAX_W'(i_b))) : i_b;
  end

  // Result fix: whole product negated for mult, quotient/remainder independently for div.
  always_comb begin
    w_hi    = i_acc[DW-1:WIDTH];
    w_lo    = i_acc[WIDTH-1:0];
    o_fixed = i_acc;
    if (i_is_div) begin
      if (i_neg_rem) w_hi = WIDTH'(twos_neg(MAX_W'(i_acc[DW-1:WIDTH])));
      if (i_neg_res) w_lo = WIDTH'(twos_neg(MAX_W'(i_acc[WIDTH-1:0])));
      o_fixed = {w_hi, w_lo};
    end else if (i_neg_res) begin
      o_fixed = DW'(twos_neg(MAX_W'(i_acc)));
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit driving the CPU HI/LO registers.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import muldiv_pkg::*;

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [DW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_a;
  logic             r_neg_b;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz_out;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [DW-1:0]    w_fixed;
  logic [WIDTH:0]   w_mul_sum;
  logic [DW-1:0]    w_mul_next;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH:0]   w_div_diff;
  logic [DW-1:0]    w_div_next;

  assign w_is_div = op_is_div(r_op);
  assign w_signed = op_is_signed(r_op);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_signed  (w_signed),
    .i_a       (r_a),
    .i_b       (r_b),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .o_neg_a   (w_neg_a),
    .o_neg_b   (w_neg_b),
    .i_acc     (r_acc),
    .i_is_div  (w_is_div),
    .i_neg_res (r_neg_a ^ r_neg_b),
    .i_neg_rem (r_neg_a),
    .o_fixed   (w_fixed)
  );

  // One radix-2 step of each datapath: shift-add multiply, restoring divide.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]} + {1'b0, r_a};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[DW-1:1]};
    w_div_rem  = r_acc[DW-1:WIDTH-1];
    w_div_diff = w_div_rem - {1'b0, r_b};
    w_div_next = w_div_diff[WIDTH] ? {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  // Control FSM with iteration counter, shared accumulator and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MULT;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_dbz     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_op    <= op_e'(op);
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_cnt   <= CNT_W'(WIDTH);
            r_acc   <= w_is_div ? {WIDTH'(0), w_mag_a} : {WIDTH'(0), w_mag_b};
            if (w_is_div && (r_b == '0)) begin
              r_dbz   <= 1'b1;
              r_state <= S_FIX;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!abort) begin
            r_done <= 1'b1;
            if (r_dbz) begin
              r_dbz_out <= 1'b1;
            end else begin
              r_hi <= w_fixed[DW-1:WIDTH];
              r_lo <= w_fixed[WIDTH-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz_out;
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        abort;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_err    = 0;

  // Architectural HI/LO as the reference model sees them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .abort       (abort),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic; divide by zero retains HI/LO.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = m_hi;
    lo  = m_lo;
    case (o)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd2: begin
        if (b == 0) dbz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          hi = rv[31:0]; lo = qv[31:0];
        end
      end
      default: begin
        if (b == 0) dbz = 1'b1;
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endtask

  // Run one op; optionally re-pulse start at edge k+restart_at, or raise abort with start.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int restart_at, input bit abort_with_start);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int          e_lat, cnt, busy_cnt;
    bit          got_done;
    ref_op(o, a, b, e_hi, e_lo, e_dbz);
    e_lat = e_dbz ? 2 : 34;
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b; abort = abort_with_start;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    a_in = $urandom; b_in = $urandom; op = 2'($urandom_range(0, 3));
    busy_cnt = busy ? 1 : 0;
    cnt = 0;
    got_done = 1'b0;
    while (!got_done && cnt < 100) begin
      start = (cnt + 1 == restart_at);
      @(posedge clock); #1;
      cnt++;
      if (done) got_done = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("latency", 64'(cnt), 64'(e_lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(e_lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("div_by_zero", 64'(div_by_zero), 64'(e_dbz));
    chk("hi", 64'(hi_out), 64'(e_hi));
    chk("lo", 64'(lo_out), 64'(e_lo));
    m_hi = e_hi;
    m_lo = e_lo;
    @(posedge clock); #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_val(input int sel);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen_done;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases.
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    chk("t1_hi_const", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("t1_lo_const", 64'(lo_out), 64'h0000_0000_FFFF_FFEB);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(2'd3, 32'd7, 32'd0, 0, 1'b0);
    chk("t4_hi_kept", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("t4_lo_kept", 64'(lo_out), 64'h0000_0000_FFFF_FFFD);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(2'd2, 32'h1234_5678, 32'd0, 0, 1'b0);
    do_op(2'd0, 32'h0001_2345, 32'hFFFF_0F0F, 5, 1'b0);
    do_op(2'd2, 32'h0000_00C8, 32'hFFFF_FFF3, 0, 1'b1);

    // Abort in IDLE does nothing.
    @(negedge clock); abort = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_hi", 64'(hi_out), 64'(m_hi));

    // Abort during RUN: busy drops, no done, HI/LO untouched.
    @(negedge clock);
    start = 1'b1; op = 2'd0; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'(m_hi));
    chk("abort_lo", 64'(lo_out), 64'(m_lo));
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      seen_done |= done;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);

    // Reset mid-RUN clears everything asynchronously.
    @(negedge clock);
    start = 1'b1; op = 2'd3; a_in = 32'd99; b_in = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (12) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi_out), 64'd0);
    chk("mid_rst_lo", 64'(lo_out), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    do_op(2'd2, 32'd5, 32'd0, 0, 1'b0);
    do_op(2'd1, 32'h0000_FFFF, 32'h0001_0001, 0, 1'b0);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), pick_val($urandom_range(0, 9)),
            pick_val($urandom_range(0, 9)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
